// File: rtl/exe_stage_mc.sv
// exe_stage_mc: forwarding, single-cycle ALU, branch resolution and iterative mul/div.
module exe_stage_mc #(
    parameter int WIDTH = 16,
    parameter int SHW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2,
    input  logic [WIDTH-1:0] imme,
    input  logic [WIDTH-1:0] pc,
    input  logic [3:0]       alu_op,
    input  logic             src_b,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [1:0]       fwd_w,
    input  logic [WIDTH-1:0] alu_back,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             br_en,
    input  logic [1:0]       jorb,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] new_pc,
    output logic             redirect
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic [SHW-1:0] cnt;
    logic [1:0] mop;
    logic [WIDTH-1:0] a, b, w, res, npc, acc, ra, rb, acc_n, ra_n, rb_n, mres, w_l, npc_l, diff;
    logic [WIDTH:0] tmp;
    logic taken, accept, multi, ge;

    function automatic logic [WIDTH-1:0] fwd(input logic [1:0] s, input logic [WIDTH-1:0] v);
        return s == 2'd0 ? v : s == 2'd1 ? alu_back : s == 2'd2 ? wb_data : '0;
    endfunction

    assign in_ready = state == IDLE;
    assign accept = in_valid & in_ready & ~flush;
    assign multi = alu_op[3:2] == 2'b11 && alu_op != 4'hf;
    assign a = fwd(fwd_a, rdata1);
    assign b = fwd(fwd_b, src_b ? imme : rdata2);
    assign w = fwd(fwd_w, rdata2);
    assign taken = br_en && (jorb[1] ? ((a == '0) ^ jorb[0]) : 1'b1);
    assign npc = taken ? (jorb == 2'b01 ? a : pc + imme) : pc + WIDTH'(1);

    always_comb begin
        res = '0;
        case (alu_op)
            4'h0: res = a + b;
            4'h1: res = a - b;
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = -a;
            4'h5: res = ~a;
            4'h6: res = a << b[SHW-1:0];
            4'h7: res = a >> b[SHW-1:0];
            4'h8: res = $signed(a) >>> b[SHW-1:0];
            4'h9: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'ha: res = {{(WIDTH-1){1'b0}}, a != b};
            4'hb: res = pc;
            default: res = '0;
        endcase
    end

    // mop 00 is shift-add multiply (acc/ra/rb = sum/multiplicand/multiplier);
    // otherwise restoring divide (acc/ra/rb = remainder/quotient/divisor)
    always_comb begin
        tmp = {acc, ra[WIDTH-1]};
        ge = tmp >= {1'b0, rb};
        diff = tmp[WIDTH-1:0] - rb;
        acc_n = mop == 2'd0 ? acc + (rb[0] ? ra : '0) : ge ? diff : tmp[WIDTH-1:0];
        ra_n = mop == 2'd0 ? ra << 1 : {ra[WIDTH-2:0], ge};
        rb_n = mop == 2'd0 ? rb >> 1 : rb;
        mres = mop == 2'd1 ? ra_n : acc_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && accept && multi) state_n = BUSY;
        if (state == BUSY && (flush || cnt == '0)) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            mop <= '0;
            acc <= '0;
            ra <= '0;
            rb <= '0;
            w_l <= '0;
            npc_l <= '0;
            out_valid <= 1'b0;
            alu_res <= '0;
            wdata <= '0;
            new_pc <= '0;
            redirect <= 1'b0;
        end else begin
            state <= state_n;
            out_valid <= 1'b0;
            if (state == IDLE && accept && multi) begin
                cnt <= SHW'(WIDTH - 1);
                mop <= alu_op[1:0];
                acc <= '0;
                ra <= a;
                rb <= b;
                w_l <= w;
                npc_l <= pc + WIDTH'(1);
            end else if (state == IDLE && accept) begin
                out_valid <= 1'b1;
                alu_res <= res;
                wdata <= w;
                new_pc <= npc;
                redirect <= taken;
            end else if (state == BUSY && !flush) begin
                acc <= acc_n;
                ra <= ra_n;
                rb <= rb_n;
                cnt <= cnt - SHW'(1);
                if (cnt == '0) begin
                    out_valid <= 1'b1;
                    alu_res <= mres;
                    wdata <= w_l;
                    new_pc <= npc_l;
                    redirect <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed vectors into a scoreboard queue, checked by an output monitor.
module tb_exe_stage_mc;
    logic clk = 0, rst = 1, in_valid = 0, flush = 0, src_b = 0, br_en = 0;
    logic [15:0] rdata1 = 0, rdata2 = 0, imme = 0, pc = 0, alu_back = 16'h0005, wb_data = 16'h0100;
    logic [3:0] alu_op = 0;
    logic [1:0] fwd_a = 0, fwd_b = 0, fwd_w = 0, jorb = 0;
    logic in_ready, out_valid, redirect;
    logic [15:0] alu_res, wdata, new_pc;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        string nm;
        logic [15:0] res, w, npc;
        logic red;
    } exp_t;
    exp_t q[$];

    exe_stage_mc #(.WIDTH(16), .SHW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .rdata1(rdata1), .rdata2(rdata2), .imme(imme), .pc(pc), .alu_op(alu_op),
        .src_b(src_b), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_w(fwd_w),
        .alu_back(alu_back), .wb_data(wb_data), .br_en(br_en), .jorb(jorb),
        .out_valid(out_valid), .alu_res(alu_res), .wdata(wdata), .new_pc(new_pc),
        .redirect(redirect)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk({e.nm, "_res"}, alu_res, e.res);
                chk({e.nm, "_wdata"}, wdata, e.w);
                chk({e.nm, "_new_pc"}, new_pc, e.npc);
                chk({e.nm, "_redirect"}, redirect, e.red);
            end
        end
    end

    task automatic send(input string nm, input logic [3:0] op, input logic [15:0] r1, r2, im, p,
                        input logic sb, input logic [1:0] fa, fb, fw, input logic be,
                        input logic [1:0] jb, input logic [15:0] er, ew, enp,
                        input logic ered, input bit push);
        int k;
        @(negedge clk);
        alu_op = op; rdata1 = r1; rdata2 = r2; imme = im; pc = p; src_b = sb;
        fwd_a = fa; fwd_b = fb; fwd_w = fw; br_en = be; jorb = jb; in_valid = 1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        if (push) q.push_back('{nm, er, ew, enp, ered});
        #1 in_valid = 0;
    endtask

    task automatic alu(input string nm, input logic [3:0] op, input logic [15:0] r1, r2,
                       input logic sb, input logic [15:0] im, input logic [15:0] er);
        send(nm, op, r1, r2, im, 16'h0100, sb, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, er, r2, 16'h0101, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int low, early, seen;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_res", alu_res, 0);
        chk("rst_new_pc", new_pc, 0);
        chk("rst_redirect", redirect, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        alu("add", 4'h0, 16'h0002, 16'h0003, 0, 0, 16'h0005);
        alu("sub", 4'h1, 16'h0005, 16'h0007, 0, 0, 16'hfffe);
        alu("and", 4'h2, 16'hf0f0, 16'hff00, 0, 0, 16'hf000);
        alu("or", 4'h3, 16'hf0f0, 16'hff00, 0, 0, 16'hfff0);
        alu("neg", 4'h4, 16'h0001, 16'h0000, 0, 0, 16'hffff);
        alu("not", 4'h5, 16'h00ff, 16'h0000, 0, 0, 16'hff00);
        alu("sll", 4'h6, 16'h0001, 16'h0009, 1, 16'h0004, 16'h0010);
        alu("srl", 4'h7, 16'h8000, 16'h0013, 0, 0, 16'h1000);
        alu("sra", 4'h8, 16'h8000, 16'h0000, 1, 16'h0003, 16'hf000);
        alu("slt_t", 4'h9, 16'hffff, 16'h0001, 0, 0, 16'h0001);
        alu("slt_f", 4'h9, 16'h0001, 16'hffff, 0, 0, 16'h0000);
        alu("ne_f", 4'ha, 16'h0003, 16'h0003, 0, 0, 16'h0000);
        alu("ne_t", 4'ha, 16'h0003, 16'h0004, 0, 0, 16'h0001);
        alu("rsvd", 4'hf, 16'h1234, 16'h5678, 0, 0, 16'h0000);
        send("pcop", 4'hb, 0, 0, 0, 16'h0234, 0, 0, 0, 0, 0, 0, 16'h0234, 0, 16'h0235, 0, 1);
        send("fwd", 4'h0, 16'h0007, 16'h0009, 0, 16'h0100, 0, 2'd2, 2'd3, 2'd1, 0, 0, 16'h0100, 16'h0005, 16'h0101, 0, 1);
        send("bnez_t", 4'h0, 0, 0, 16'h0004, 16'h0010, 0, 2'd1, 0, 0, 1, 2'd3, 16'h0005, 0, 16'h0014, 1, 1);
        send("bnez_f", 4'h0, 0, 0, 16'h0004, 16'h0010, 0, 2'd0, 0, 0, 1, 2'd3, 16'h0000, 0, 16'h0011, 0, 1);
        send("beqz_t", 4'h0, 0, 0, 16'h0004, 16'h0010, 0, 0, 0, 0, 1, 2'd2, 16'h0000, 0, 16'h0014, 1, 1);
        send("jr", 4'h0, 16'h0040, 0, 16'h0004, 16'h0010, 0, 0, 0, 0, 1, 2'd1, 16'h0040, 0, 16'h0040, 1, 1);
        send("b", 4'h0, 0, 0, 16'hfff0, 16'h0020, 0, 0, 0, 0, 1, 2'd0, 16'h0000, 0, 16'h0010, 1, 1);

        alu("mul", 4'hc, 16'h0123, 16'h0010, 0, 0, 16'h1230);
        low = 0; early = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!in_ready) low++;
            if (out_valid) early++;
        end
        @(negedge clk);
        chk("mul_ready_low_cycles", low, 16);
        chk("mul_early_valid", early, 0);
        chk("mul_valid_latency", out_valid, 1);
        chk("mul_ready_back", in_ready, 1);

        alu("divu", 4'hd, 16'd100, 16'd7, 0, 0, 16'h000e);
        alu("remu", 4'he, 16'd100, 16'd7, 0, 0, 16'h0002);
        alu("divu0", 4'hd, 16'h1234, 16'h0000, 0, 0, 16'hffff);
        alu("remu0", 4'he, 16'h1234, 16'h0000, 0, 0, 16'h1234);
        send("divu_fwd", 4'hd, 0, 16'd7, 0, 16'h0100, 0, 2'd2, 0, 0, 0, 0, 16'h0024, 16'd7, 16'h0101, 0, 1);
        wb_data = 16'hdead;
        alu("mul_after", 4'hc, 16'h0003, 16'h0005, 0, 0, 16'h000f);
        wb_data = 16'h0100;

        send("divu_flushed", 4'hd, 16'd100, 16'd7, 0, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        chk("flush_ready", in_ready, 1);
        chk("flush_no_valid", out_valid, 0);
        alu("add_after_flush", 4'h0, 16'h0002, 16'h0003, 0, 0, 16'h0005);
        @(negedge clk);
        chk("add_after_flush_valid", out_valid, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_late_valid", seen, 0);

        @(negedge clk);
        alu_op = 4'h0; rdata1 = 1; rdata2 = 1; fwd_a = 0; fwd_b = 0; br_en = 0;
        in_valid = 1; flush = 1;
        @(posedge clk);
        #1 in_valid = 0; flush = 0;
        @(negedge clk);
        chk("idle_flush_no_valid", out_valid, 0);
        chk("idle_flush_ready", in_ready, 1);

        send("mul_rst", 4'hc, 16'h0123, 16'h0010, 0, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        chk("mul_rst_busy", in_ready, 0);
        rst = 1;
        #1;
        chk("async_rst_ready", in_ready, 1);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_res", alu_res, 0);
        chk("async_rst_wdata", wdata, 0);
        chk("async_rst_new_pc", new_pc, 0);
        chk("async_rst_redirect", redirect, 0);
        @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
